rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 32 +++
 rtl/rob.sv | 134 +++++++++++++
 tb/tb_rob.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   ROB_DEPTH / ROB_ID_W / ROB_CNT_W : buffer geometry
//   rob_kind_e                       : entry kind encoding (ALU, BRANCH, JUMP)
//   rob_entry_t                      : contents of one buffer slot
//   kind_flushes()                   : true when retiring this entry redirects fetch
package rob_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_ID_W  = 5;
  localparam int ROB_CNT_W = 6;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JUMP   = 2'd2
  } rob_kind_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_kind_e   kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        cond;
  } rob_entry_t;

  function automatic logic kind_flushes(rob_kind_e kind, logic cond);
    return (kind == KIND_JUMP) || ((kind == KIND_BRANCH) && cond);
  endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: 32-entry circular buffer that allocates entries in program
// order, collects results from the CDB and retires completed entries in order,
// one per cycle, emitting a register-write pulse and/or a pipeline flush.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   issue_en_i/rd_i/kind_i    allocate one entry at the tail
//   issue_id_o, full_o        id of the next allocation, buffer full
//   cdb_en_i/id_ROB_i/data_i/pc_i/cond_i   result broadcast into an entry
//   commit_en_o/rd_o/data_o/id_o           registered register-write pulse
//   flush_o, flush_pc_o                    registered flush pulse and target
module rob
  import rob_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [1:0]          issue_kind_i,
  output logic [ROB_ID_W-1:0] issue_id_o,
  output logic                full_o,
  input  logic                cdb_en_i,
  input  logic [ROB_ID_W-1:0] cdb_id_ROB_i,
  input  logic [31:0]         cdb_data_i,
  input  logic [31:0]         cdb_pc_i,
  input  logic                cdb_cond_i,
  output logic                commit_en_o,
  output logic [4:0]          commit_rd_o,
  output logic [31:0]         commit_data_o,
  output logic [ROB_ID_W-1:0] commit_id_o,
  output logic                flush_o,
  output logic [31:0]         flush_pc_o
);

  rob_entry_t              ent [ROB_DEPTH];
  logic [ROB_ID_W-1:0]     head;
  logic [ROB_ID_W-1:0]     tail;
  logic [ROB_CNT_W-1:0]    count;

  rob_entry_t              head_ent;
  logic                    do_retire;
  logic                    do_flush;
  logic                    do_issue;
  logic                    do_cdb;

  assign full_o     = (count == ROB_CNT_W'(ROB_DEPTH));
  assign issue_id_o = tail;

  // Retire looks only at registered state, so a result written by the CDB
  // at this edge cannot retire until the following edge.
  always_comb begin
    head_ent  = ent[head];
    do_retire = (count != '0) && head_ent.ready;
    do_flush  = do_retire && kind_flushes(head_ent.kind, head_ent.cond);
    // A retire frees the head slot, so a full buffer can still accept an issue.
    do_issue  = issue_en_i && (!full_o || do_retire) && !do_flush;
    do_cdb    = cdb_en_i && ent[cdb_id_ROB_i].busy && !do_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_en_o   <= 1'b0;
      commit_rd_o   <= '0;
      commit_data_o <= '0;
      commit_id_o   <= '0;
      flush_o       <= 1'b0;
      flush_pc_o    <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent[i].busy  <= 1'b0;
        ent[i].ready <= 1'b0;
      end
    end else begin
      commit_en_o   <= 1'b0;
      commit_rd_o   <= '0;
      commit_data_o <= '0;
      commit_id_o   <= '0;
      flush_o       <= 1'b0;
      flush_pc_o    <= '0;

      if (do_retire) begin
        commit_en_o   <= (head_ent.rd != '0) && (head_ent.kind != KIND_BRANCH);
        commit_rd_o   <= head_ent.rd;
        commit_data_o <= head_ent.data;
        commit_id_o   <= head;
        if (do_flush) begin
          flush_o    <= 1'b1;
          flush_pc_o <= head_ent.pc;
        end
      end

      if (do_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
      end else begin
        // Ordering matters: the retire clear overrides a CDB write to the head,
        // and a new issue into the just-freed slot overrides both.
        if (do_cdb) begin
          ent[cdb_id_ROB_i].data  <= cdb_data_i;
          ent[cdb_id_ROB_i].pc    <= cdb_pc_i;
          ent[cdb_id_ROB_i].cond  <= cdb_cond_i;
          ent[cdb_id_ROB_i].ready <= 1'b1;
        end
        if (do_retire) begin
          ent[head].busy  <= 1'b0;
          ent[head].ready <= 1'b0;
          head            <= head + ROB_ID_W'(1);
        end
        if (do_issue) begin
          ent[tail] <= '{busy:  1'b1,
                         ready: 1'b0,
                         kind:  rob_kind_e'(issue_kind_i),
                         rd:    issue_rd_i,
                         data:  32'd0,
                         pc:    32'd0,
                         cond:  1'b0};
          tail      <= tail + ROB_ID_W'(1);
        end
        case ({do_issue, do_retire})
          2'b10:   count <= count + ROB_CNT_W'(1);
          2'b01:   count <= count - ROB_CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob. A queue-based model of the in-flight program
// order predicts every registered output each cycle; directed scenarios add
// literal expectations that pin the model.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en_i;
  logic [4:0]  issue_rd_i;
  logic [1:0]  issue_kind_i;
  logic [4:0]  issue_id_o;
  logic        full_o;
  logic        cdb_en_i;
  logic [4:0]  cdb_id_ROB_i;
  logic [31:0] cdb_data_i;
  logic [31:0] cdb_pc_i;
  logic        cdb_cond_i;
  logic        commit_en_o;
  logic [4:0]  commit_rd_o;
  logic [31:0] commit_data_o;
  logic [4:0]  commit_id_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;

  rob dut (
    .clk(clk), .rst(rst),
    .issue_en_i(issue_en_i), .issue_rd_i(issue_rd_i), .issue_kind_i(issue_kind_i),
    .issue_id_o(issue_id_o), .full_o(full_o),
    .cdb_en_i(cdb_en_i), .cdb_id_ROB_i(cdb_id_ROB_i), .cdb_data_i(cdb_data_i),
    .cdb_pc_i(cdb_pc_i), .cdb_cond_i(cdb_cond_i),
    .commit_en_o(commit_en_o), .commit_rd_o(commit_rd_o), .commit_data_o(commit_data_o),
    .commit_id_o(commit_id_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model: program-order queue of live ids ----------------
  int          q[$];
  bit          m_ready [32];
  int          m_kind  [32];
  logic [4:0]  m_rd    [32];
  logic [31:0] m_data  [32];
  logic [31:0] m_pc    [32];
  bit          m_cond  [32];
  int          nid = 0;
  bit          mvalid = 0;
  bit          exp_ret, exp_cen, exp_fl;
  logic [4:0]  exp_rd, exp_id;
  logic [31:0] exp_data, exp_pc;
  int          h;

  function automatic bit in_q(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      nid = 0;
      exp_ret = 0; exp_cen = 0; exp_fl = 0;
      exp_rd = 0; exp_id = 0; exp_data = 0; exp_pc = 0;
      mvalid = 1;
    end else begin
      exp_ret = (q.size() > 0) && m_ready[q[0]];
      exp_cen = 0; exp_fl = 0; exp_rd = 0; exp_id = 0; exp_data = 0; exp_pc = 0;
      if (exp_ret) begin
        h        = q[0];
        exp_id   = 5'(h);
        exp_rd   = m_rd[h];
        exp_data = m_data[h];
        exp_cen  = (m_kind[h] != 1) && (m_rd[h] != 0);
        exp_fl   = (m_kind[h] == 2) || ((m_kind[h] == 1) && m_cond[h]);
        if (exp_fl) exp_pc = m_pc[h];
      end
      if (exp_fl) begin
        q.delete();
        nid = 0;
      end else begin
        if (cdb_en_i && in_q(int'(cdb_id_ROB_i))) begin
          m_data[cdb_id_ROB_i]  = cdb_data_i;
          m_pc[cdb_id_ROB_i]    = cdb_pc_i;
          m_cond[cdb_id_ROB_i]  = cdb_cond_i;
          m_ready[cdb_id_ROB_i] = 1;
        end
        if (exp_ret) void'(q.pop_front());
        if (issue_en_i && q.size() < 32) begin
          q.push_back(nid);
          m_kind[nid]  = int'(issue_kind_i);
          m_rd[nid]    = issue_rd_i;
          m_ready[nid] = 0;
          m_cond[nid]  = 0;
          nid = (nid + 1) % 32;
        end
      end
    end
  end

  // ---------------- per-cycle compare + commit log ----------------
  logic [4:0]  log_rd[$];
  logic [31:0] log_data[$];
  logic [4:0]  log_id[$];

  always @(negedge clk) begin
    if (mvalid) begin
      chk("commit_en", 32'(commit_en_o), 32'(exp_cen));
      chk("flush", 32'(flush_o), 32'(exp_fl));
      if (exp_ret) begin
        if (exp_cen) begin
          chk("commit_rd", 32'(commit_rd_o), 32'(exp_rd));
          chk("commit_data", commit_data_o, exp_data);
          chk("commit_id", 32'(commit_id_o), 32'(exp_id));
        end
        if (exp_fl) chk("flush_pc", flush_pc_o, exp_pc);
      end else begin
        chk("idle_outs", {commit_data_o ^ flush_pc_o}, 32'd0);
        chk("idle_rd_id", 32'({commit_rd_o, commit_id_o}), 32'd0);
        chk("idle_pc", flush_pc_o, 32'd0);
      end
      chk("issue_id", 32'(issue_id_o), 32'(nid));
      chk("full", 32'(full_o), 32'(q.size() == 32));
      if (commit_en_o === 1'b1) begin
        log_rd.push_back(commit_rd_o);
        log_data.push_back(commit_data_o);
        log_id.push_back(commit_id_o);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [1:0] k, input logic [4:0] rd);
    issue_en_i = 1; issue_kind_i = k; issue_rd_i = rd;
    @(negedge clk);
    issue_en_i = 0;
  endtask

  task automatic cdb(input logic [4:0] id, input logic [31:0] d, input logic [31:0] pc, input logic c);
    cdb_en_i = 1; cdb_id_ROB_i = id; cdb_data_i = d; cdb_pc_i = pc; cdb_cond_i = c;
    @(negedge clk);
    cdb_en_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  int base;

  initial begin
    rst = 1; issue_en_i = 0; issue_rd_i = 0; issue_kind_i = 0;
    cdb_en_i = 0; cdb_id_ROB_i = 0; cdb_data_i = 0; cdb_pc_i = 0; cdb_cond_i = 0;
    idle(2);
    rst = 0;
    chk("reset_full", 32'(full_o), 32'd0);
    chk("reset_id", 32'(issue_id_o), 32'd0);
    chk("reset_commit", 32'(commit_en_o), 32'd0);

    // In-order retire with out-of-order completion
    base = log_rd.size();
    issue(0, 5'd1); issue(0, 5'd2); issue(0, 5'd3);
    chk("s1_tail", 32'(issue_id_o), 32'd3);
    cdb(5'd2, 32'hA, 0, 0);
    cdb(5'd0, 32'hB, 0, 0);
    cdb(5'd1, 32'hC, 0, 0);
    chk("s1_first_rd", 32'(commit_rd_o), 32'd1);
    chk("s1_first_data", commit_data_o, 32'hB);
    idle(3);
    chk("s1_ncommits", 32'(log_rd.size() - base), 32'd3);
    if (log_rd.size() - base == 3) begin
      chk("s1_c0", {log_rd[base],   log_data[base][26:0]},   {5'd1, 27'hB});
      chk("s1_c1", {log_rd[base+1], log_data[base+1][26:0]}, {5'd2, 27'hC});
      chk("s1_c2", {log_rd[base+2], log_data[base+2][26:0]}, {5'd3, 27'hA});
    end

    // Full and wrap-around
    do_reset();
    for (int i = 0; i < 32; i++) issue(0, 5'(i % 31 + 1));
    chk("s2_full", 32'(full_o), 32'd1);
    chk("s2_wrap_id", 32'(issue_id_o), 32'd0);
    issue(0, 5'd9);
    chk("s2_33rd_full", 32'(full_o), 32'd1);
    chk("s2_33rd_id", 32'(issue_id_o), 32'd0);
    cdb(5'd0, 32'h55, 0, 0);
    issue(0, 5'd9);
    chk("s2_ret_id", 32'(commit_id_o), 32'd0);
    chk("s2_ret_data", commit_data_o, 32'h55);
    chk("s2_still_full", 32'(full_o), 32'd1);
    chk("s2_next_id", 32'(issue_id_o), 32'd1);
    idle(2);

    // Taken branch flushes a ready younger entry; issue/CDB at flush edge dropped
    do_reset();
    base = log_rd.size();
    issue(1, 5'd0); issue(0, 5'd4);
    cdb(5'd1, 32'h77, 0, 0);
    cdb(5'd0, 32'h0, 32'h100, 1);
    issue_en_i = 1; issue_kind_i = 0; issue_rd_i = 5'd6;
    cdb_en_i = 1; cdb_id_ROB_i = 5'd1; cdb_data_i = 32'hDEAD; cdb_pc_i = 0; cdb_cond_i = 0;
    @(negedge clk);
    issue_en_i = 0; cdb_en_i = 0;
    chk("s3_flush", 32'(flush_o), 32'd1);
    chk("s3_flush_pc", flush_pc_o, 32'h100);
    chk("s3_no_commit", 32'(commit_en_o), 32'd0);
    chk("s3_tail", 32'(issue_id_o), 32'd0);
    idle(3);
    chk("s3_no_id1", 32'(log_rd.size() - base), 32'd0);

    // JUMP retire: link write plus redirect
    issue(2, 5'd1);
    cdb(5'd0, 32'h24, 32'h80, 0);
    idle(1);
    chk("s4_cen", 32'(commit_en_o), 32'd1);
    chk("s4_rd", 32'(commit_rd_o), 32'd1);
    chk("s4_data", commit_data_o, 32'h24);
    chk("s4_flush", 32'(flush_o), 32'd1);
    chk("s4_pc", flush_pc_o, 32'h80);

    // Not-taken branch: no write, no flush
    issue(1, 5'd3);
    cdb(5'd0, 32'h0, 32'h200, 0);
    idle(1);
    chk("s4b_flush", 32'(flush_o), 32'd0);
    chk("s4b_cen", 32'(commit_en_o), 32'd0);
    chk("s4b_tail", 32'(issue_id_o), 32'd1);

    // Ignored writes: CDB to idle ids, rd=0 ALU
    base = log_rd.size();
    cdb(5'd5, 32'h99, 0, 0);
    issue(0, 5'd0);
    idle(1);
    cdb(5'd1, 32'h33, 0, 0);
    idle(1);
    chk("s5_rd0_cen", 32'(commit_en_o), 32'd0);
    for (int i = 0; i < 4; i++) issue(0, 5'd7);
    idle(3);
    chk("s5_stale_cdb", 32'(log_rd.size() - base), 32'd0);
    chk("s5_tail", 32'(issue_id_o), 32'd6);
    for (int i = 2; i < 6; i++) cdb(5'(i), 32'(i * 16), 0, 0);
    idle(2);
    chk("s5_drain", 32'(log_rd.size() - base), 32'd4);

    // Reset mid-operation beats a pending retire, issue and CDB
    do_reset();
    for (int i = 0; i < 5; i++) issue(0, 5'(i + 1));
    cdb(5'd0, 32'h11, 0, 0);
    rst = 1; issue_en_i = 1; issue_kind_i = 0; issue_rd_i = 5'd2;
    cdb_en_i = 1; cdb_id_ROB_i = 5'd1; cdb_data_i = 32'h22;
    @(negedge clk);
    rst = 0; issue_en_i = 0; cdb_en_i = 0;
    chk("s6_full", 32'(full_o), 32'd0);
    chk("s6_id", 32'(issue_id_o), 32'd0);
    chk("s6_outs", 32'({commit_en_o, flush_o, commit_rd_o, commit_id_o}), 32'd0);
    chk("s6_data_pc", commit_data_o | flush_pc_o, 32'd0);
    base = log_rd.size();
    issue(0, 5'd8);
    chk("s6_first_id", 32'(issue_id_o), 32'd1);
    idle(3);
    chk("s6_lost", 32'(log_rd.size() - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
